// File: rtl/dm_sweep_gen.sv
// Mod edge (either polarity) starts up to SEGS square-wave segments of (div+1)*(cyc+1) cycles each.
// busy rises 2 edges after mod is first sampled; there is no backpressure, and abort stops on the next edge.
module dm_sweep_gen #(
  parameter int SEGS    = 3,
  parameter int DIV_W   = 7,
  parameter int CYC_W   = 10,
  parameter int DEF_DIV = 41,
  parameter int DEF_CYC = 2,
  parameter int SEG_W   = $clog2(SEGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mod,
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_addr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CYC_W-1:0] cfg_cyc,
  input  logic [SEG_W-1:0] seg_last,
  input  logic             continuous,
  input  logic             abort,
  output logic             signal,
  output logic             out_mod,
  output logic             busy,
  output logic [SEG_W-1:0] seg_idx,
  output logic             seg_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2, sync3;
  logic             trig;
  logic [DIV_W-1:0] div_tab [SEGS];
  logic [CYC_W-1:0] cyc_tab [SEGS];
  logic [DIV_W-1:0] div_sh;
  logic [CYC_W-1:0] cyc_sh;
  logic [DIV_W-1:0] ctr, ctr_nxt;
  logic [CYC_W-1:0] cyc_ctr, cyc_nxt;
  logic [SEG_W-1:0] idx_nxt;
  logic [SEG_W-1:0] eff_last;
  logic [DIV_W-1:0] half;
  logic             sig_nxt;
  logic             done_nxt;
  logic             load_sh;
  logic             period_end;
  logic             seg_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= mod;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign out_mod = sync2;
  assign trig    = sync2 ^ sync3;

  // Out-of-range addresses are dropped so a non-power-of-two table never aliases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SEGS; i++) begin
        div_tab[i] <= DIV_W'(DEF_DIV);
        cyc_tab[i] <= CYC_W'(DEF_CYC);
      end
    end else if (cfg_we && (int'(cfg_addr) < SEGS)) begin
      div_tab[cfg_addr] <= cfg_div;
      cyc_tab[cfg_addr] <= cfg_cyc;
    end
  end

  assign half       = (div_sh - DIV_W'(1)) >> 1;
  assign period_end = (ctr == div_sh);
  assign seg_end    = period_end && (cyc_ctr == cyc_sh);
  assign eff_last   = (int'(seg_last) > SEGS - 1) ? SEG_W'(SEGS - 1) : seg_last;
  assign busy       = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    cyc_nxt   = cyc_ctr;
    idx_nxt   = seg_idx;
    sig_nxt   = signal;
    done_nxt  = 1'b0;
    load_sh   = 1'b0;
    case (state)
      IDLE: begin
        sig_nxt = 1'b1;
        ctr_nxt = '0;
        cyc_nxt = '0;
        idx_nxt = '0;
        if (trig && !abort) begin
          state_nxt = RUN;
          load_sh   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          sig_nxt   = 1'b1;
          ctr_nxt   = '0;
          cyc_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          if (ctr == half) sig_nxt = 1'b0;
          if (period_end) begin
            sig_nxt = 1'b1;
            ctr_nxt = '0;
            cyc_nxt = cyc_ctr + CYC_W'(1);
          end else begin
            ctr_nxt = ctr + DIV_W'(1);
          end
          if (seg_end) begin
            done_nxt = 1'b1;
            cyc_nxt  = '0;
            load_sh  = 1'b1;
            if (seg_idx < eff_last) begin
              idx_nxt = seg_idx + SEG_W'(1);
            end else if (continuous) begin
              idx_nxt = '0;
            end else begin
              state_nxt = IDLE;
              idx_nxt   = '0;
              load_sh   = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadows read the table before any same-edge write lands, so the entered segment sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr      <= '0;
      cyc_ctr  <= '0;
      seg_idx  <= '0;
      signal   <= 1'b1;
      seg_done <= 1'b0;
      div_sh   <= DIV_W'(DEF_DIV);
      cyc_sh   <= CYC_W'(DEF_CYC);
    end else begin
      ctr      <= ctr_nxt;
      cyc_ctr  <= cyc_nxt;
      seg_idx  <= idx_nxt;
      signal   <= sig_nxt;
      seg_done <= done_nxt;
      if (load_sh) begin
        div_sh <= div_tab[idx_nxt];
        cyc_sh <= cyc_tab[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_dm_sweep_gen.sv
// Directed bench for dm_sweep_gen: expected waveforms are built from per-segment {div,cyc} lists.
module tb_dm_sweep_gen;
  localparam int SEGS  = 3;
  localparam int DIV_W = 7;
  localparam int CYC_W = 10;
  localparam int SEG_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mod = 1'b0;
  logic             cfg_we = 1'b0;
  logic [SEG_W-1:0] cfg_addr = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [CYC_W-1:0] cfg_cyc = '0;
  logic [SEG_W-1:0] seg_last = '0;
  logic             continuous = 1'b0;
  logic             abort = 1'b0;
  logic             signal, out_mod, busy, seg_done;
  logic [SEG_W-1:0] seg_idx;

  dm_sweep_gen #(.SEGS(SEGS), .DIV_W(DIV_W), .CYC_W(CYC_W), .DEF_DIV(41), .DEF_CYC(2)) dut (
    .clk(clk), .rst(rst), .mod(mod), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_div(cfg_div), .cfg_cyc(cfg_cyc), .seg_last(seg_last), .continuous(continuous),
    .abort(abort), .signal(signal), .out_mod(out_mod), .busy(busy),
    .seg_idx(seg_idx), .seg_done(seg_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit sig_q[$];
  bit exp_q[$];
  int done_q[$];
  int expd_q[$];
  int blen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr;
    exp_q.delete();
    expd_q.delete();
  endtask

  // One segment: cyc+1 periods of (half+1) high cycles then div-half low cycles.
  task automatic add_seg(input int div, input int cyc);
    int h;
    h = (div - 1) / 2;
    for (int p = 0; p <= cyc; p++)
      for (int i = 0; i <= div; i++)
        exp_q.push_back(i <= h);
  endtask

  task automatic write_tab(input int a, input int d, input int c);
    cfg_addr = a[SEG_W-1:0];
    cfg_div  = d[DIV_W-1:0];
    cfg_cyc  = c[CYC_W-1:0];
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Sample n is taken on the falling edge n cycles after busy is first seen high.
  task automatic capture(input int max_n, output int len);
    int n;
    sig_q.delete();
    done_q.delete();
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", busy, 1);
    len = 0;
    if (busy) begin
      n = 0;
      forever begin
        if (seg_done) done_q.push_back(n);
        if (!busy || n >= max_n) break;
        sig_q.push_back(signal);
        @(negedge clk);
        n++;
      end
      len = n;
    end
  endtask

  task automatic verify(input string tag, input int len, input int exp_len);
    int mism;
    check({tag, "_busy_len"}, len, exp_len);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= sig_q.size() || sig_q[i] !== exp_q[i]) mism++;
    check({tag, "_wave_mism"}, mism, 0);
    check({tag, "_ndone"}, done_q.size(), expd_q.size());
    for (int i = 0; i < expd_q.size(); i++)
      check($sformatf("%s_done%0d", tag, i), (i < done_q.size()) ? done_q[i] : -1, expd_q[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_signal", signal, 1);
    check("rst_busy", busy, 0);
    check("rst_seg_idx", seg_idx, 0);
    check("rst_seg_done", seg_done, 0);
    check("rst_out_mod", out_mod, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single shot with trigger latency
    write_tab(1, 39, 3);
    write_tab(2, 37, 2);
    seg_last = 2;
    continuous = 1'b0;
    mod = ~mod;
    @(negedge clk);
    check("lat_out_mod_k", out_mod, 0);
    @(negedge clk);
    check("lat_out_mod_k1", out_mod, 1);
    check("lat_busy_k1", busy, 0);
    @(negedge clk);
    check("lat_busy_k2", busy, 1);
    clr;
    add_seg(41, 2); add_seg(39, 3); add_seg(37, 2);
    expd_q = '{126, 286, 400};
    capture(1000, blen);
    verify("single", blen, 400);
    check("single_end_signal", signal, 1);
    check("single_end_idx", seg_idx, 0);

    // Odd divider
    write_tab(0, 4, 1);
    seg_last = 0;
    mod = ~mod;
    clr;
    add_seg(4, 1);
    expd_q = '{10};
    capture(100, blen);
    verify("odd", blen, 10);
    write_tab(0, 41, 2);

    // Continuous then abort inside segment 1
    seg_last = 2;
    continuous = 1'b1;
    mod = ~mod;
    clr;
    repeat (2) begin add_seg(41, 2); add_seg(39, 3); add_seg(37, 2); end
    expd_q = '{126, 286, 400, 526, 686, 800};
    capture(800, blen);
    verify("cont", blen, 800);
    check("cont_wrap_idx", seg_idx, 0);
    repeat (130) @(negedge clk);
    check("cont_seg1_idx", seg_idx, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_signal", signal, 1);
    check("abort_seg_done", seg_done, 0);
    check("abort_idx", seg_idx, 0);
    @(negedge clk);
    check("abort_no_done", seg_done, 0);

    // Abort held across a trigger in IDLE
    abort = 1'b1;
    mod = ~mod;
    repeat (4) @(negedge clk);
    check("abort_trig_busy", busy, 0);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_trig_late", busy, 0);

    // Runtime writes during segment 1, plus an out-of-range address
    mod = ~mod;
    clr;
    add_seg(41, 2); add_seg(39, 3); add_seg(37, 2);
    add_seg(41, 2); add_seg(9, 0);  add_seg(37, 2);
    expd_q = '{126, 286, 400, 526, 536, 650};
    fork
      capture(650, blen);
      begin
        repeat (152) @(negedge clk);
        write_tab(1, 9, 0);
        write_tab(3, 1, 1);
      end
    join
    verify("rtw", blen, 650);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("rtw_abort_busy", busy, 0);

    // Retrigger while busy and seg_last clamp
    write_tab(1, 39, 3);
    seg_last = 3;
    continuous = 1'b0;
    mod = ~mod;
    clr;
    add_seg(41, 2); add_seg(39, 3); add_seg(37, 2);
    expd_q = '{126, 286, 400};
    fork
      capture(1000, blen);
      begin
        repeat (53) @(negedge clk);
        mod = ~mod;
        repeat (150) @(negedge clk);
        mod = ~mod;
      end
    join
    verify("retrig", blen, 400);
    repeat (5) @(negedge clk);
    check("retrig_idle", busy, 0);

    // Asynchronous reset mid-run restores the default table
    seg_last = 2;
    write_tab(0, 100, 5);
    write_tab(1, 9, 0);
    write_tab(2, 5, 0);
    mod = ~mod;
    repeat (40) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    mod = 1'b0;
    #1;
    check("arst_signal", signal, 1);
    check("arst_busy", busy, 0);
    check("arst_seg_idx", seg_idx, 0);
    check("arst_seg_done", seg_done, 0);
    check("arst_out_mod", out_mod, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);
    mod = 1'b1;
    clr;
    add_seg(41, 2); add_seg(41, 2); add_seg(41, 2);
    expd_q = '{126, 252, 378};
    capture(1000, blen);
    verify("post_rst", blen, 378);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dm_sweep_gen.md
# dm_sweep_gen

Parametrised multi-segment frequency-sweep square-wave generator for the DE0 TDC stimulus path. A synchronised edge (either polarity) on `mod` starts a sequence of up to `SEGS` segments. Each segment emits a fixed number of square-wave periods at its own programmable divide ratio. The block supports runtime-writable segment tables, single-shot or continuous operation, and abort.

## Interface
Parameters:
- `SEGS`, 3: number of segment table entries; must be ≥ 2.
- `DIV_W`, 7: width of the period divider (period = div+1 clk cycles).
- `CYC_W`, 10: width of the per-segment period count (periods = cyc+1).
- `DEF_DIV`, 41: reset value of every table `div` entry.
- `DEF_CYC`, 2: reset value of every table `cyc` entry.
- `SEG_W`, $clog2(SEGS): segment index width (derived).

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mod` in 1: asynchronous trigger; synchronised internally by 2 flops.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in SEG_W: table entry to write.
- `cfg_div` in DIV_W: divider value to write; values < 1 are illegal.
- `cfg_cyc` in CYC_W: period count to write.
- `seg_last` in SEG_W: index of the last active segment.
- `continuous` in 1: 1 = wrap to segment 0 after `seg_last`; 0 = stop.
- `abort` in 1: synchronous stop request.
- `signal` out 1: generated square wave.
- `out_mod` out 1: synchronised `mod` (output of the 2nd sync flop).
- `busy` out 1: high while RUN.
- `seg_idx` out SEG_W: current segment index.
- `seg_done` out 1: one-cycle pulse on completion of each segment.

## Operation
- **States:**
  - IDLE: `signal` = 1, counters held at 0, `seg_idx` = 0.
  - RUN: counters active.
- **Trigger:** `edge` = `out_mod` XOR its 1-cycle-delayed copy.
  - IDLE & `edge` & !`abort` → RUN, `seg_idx` = 0, `ctr` = 0, `cyc_ctr` = 0.
  - `edge` in RUN is ignored.
- **Shadow registers:** on every segment entry, `div`/`cyc` of the entered segment are latched into shadow registers. Table writes never affect the running segment.
- **Divider** (RUN only):
  - `ctr` counts 0..`div`, then wraps to 0.
  - `half` = (`div`−1)>>1.
  - `signal` toggles on the edge where `ctr` == `half` (→0) and where `ctr` == `div` (→1).
  - Each period is therefore high for `half`+1 cycles, and low for the rest.
- **Period count:** `cyc_ctr` increments at each `ctr` == `div`.
  - When `ctr` == `div` and `cyc_ctr` == `cyc`, the segment ends.
  - On segment end: `seg_done` pulses for 1 cycle, then `ctr` and `cyc_ctr` go to 0.
- **Segment advance:**
  - If `seg_idx` < `eff_last`: `seg_idx` + 1.
  - Else if `continuous`: `seg_idx` = 0, with no idle gap.
  - Else: → IDLE; `signal` is already 1.
  - `eff_last` = min(`seg_last`, SEGS−1), sampled at each segment end.
- **Abort:** `abort` in RUN → IDLE on the next edge; `signal` forced to 1, counters cleared, no `seg_done`.
  - `abort` together with segment end: abort wins, no `seg_done`.
  - `abort` together with a trigger in IDLE: stays IDLE.
- **Table writes:**
  - `cfg_we` writes `cfg_div`/`cfg_cyc` to entry `cfg_addr`; a write with `cfg_addr` ≥ SEGS is ignored.
  - A write to the entry being entered on the same edge: the shadow registers take the old table value.
- **Reset:** `rst` asserted at any time returns the block to IDLE immediately.
  - Outputs: `signal` = 1, `busy` = 0, `seg_idx` = 0, `seg_done` = 0, `out_mod` = 0.
  - Sync flops = 0; table = DEF_DIV/DEF_CYC.

## Timing
- `mod` new value first sampled at edge k:
  - `out_mod` changes at k+1.
  - `busy` = 1 from k+2.
  - First `signal` fall at k+3+`half`.
- Segment length = (div+1)·(cyc+1) cycles, exact, with no gaps between segments.
- `seg_done` is registered: high for the cycle after the segment's final `ctr` == `div` edge.
- Single-shot: `busy` falls on the same edge as the last `seg_done` rises.

## Test plan
- **Reset:** assert `rst` mid-RUN.
  - Required: `signal` = 1, `busy` = 0, `seg_idx` = 0, `seg_done` = 0 asynchronously.
  - Required: table reads back 41/2 on the next run.
- **Single shot:** table {41,2},{39,3},{37,2}, `seg_last` = 2, `continuous` = 0, toggle `mod`.
  - Required: 3 periods 21H/21L, then 4 periods 20H/20L, then 3 periods 19H/19L.
  - Required: `busy` high exactly 400 cycles; 3 `seg_done` pulses, at cycles 126, 286 and 400 after `busy` rises.
- **Continuous:** same table, `continuous` = 1.
  - Required: seamless 400-cycle repeating pattern.
  - Then assert `abort` during segment 1. Required: `busy` = 0 and `signal` = 1 one cycle later, no `seg_done`.
- **Odd period:** entry 0 = {4,1}, `seg_last` = 0.
  - Required: 2 periods of 2H/3L, `busy` for 10 cycles.
- **Runtime writes:** write entry 1 = {9,0} while segment 1 runs with {39,3}.
  - Required: the current segment completes at 40×4 cycles; the next loop uses 10-cycle single period.
  - Also: a write with `cfg_addr` = 3 (SEGS = 3) changes nothing.
- **Retrigger/clamp:** toggle `mod` while `busy`: sequence unaffected.
  - `seg_last` = 3 with SEGS = 3 behaves as `seg_last` = 2.
